// File: rtl/home_pkg.sv
// Shared constants for the home alert scheduler: FSM state codes, display codes
// and the bit layout of the pending-request vector.
package home_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SERVE   = 2'd1;
  localparam state_t ST_GAP     = 2'd2;
  localparam state_t ST_CLIMATE = 2'd3;

  // Pending vector bit indices; a higher index means a higher priority
  localparam logic [1:0] PEND_FIRE  = 2'd3;
  localparam logic [1:0] PEND_FDOOR = 2'd2;
  localparam logic [1:0] PEND_RDOOR = 2'd1;
  localparam logic [1:0] PEND_WIN   = 2'd0;

  // Front-panel display codes
  localparam logic [2:0] DISP_NONE   = 3'b000;
  localparam logic [2:0] DISP_FIRE   = 3'b001;
  localparam logic [2:0] DISP_FDOOR  = 3'b010;
  localparam logic [2:0] DISP_RDOOR  = 3'b011;
  localparam logic [2:0] DISP_WIN    = 3'b100;
  localparam logic [2:0] DISP_HEATER = 3'b101;
  localparam logic [2:0] DISP_COOLER = 3'b110;

  // Display code shown while a given pending bit is being served
  function automatic logic [2:0] disp_code(input logic [1:0] idx);
    logic [2:0] code;
    case (idx)
      PEND_FIRE:  code = DISP_FIRE;
      PEND_FDOOR: code = DISP_FDOOR;
      PEND_RDOOR: code = DISP_RDOOR;
      default:    code = DISP_WIN;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Down-counter that times how long one event output stays asserted.
// Loaded with HOLD_CYCLES-1, decremented on request, saturates at zero.
module hold_timer #(
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic Clk,
  input  logic Rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(HOLD_CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  // Next count: load wins over decrement; never wraps below zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/alert_scheduler.sv
// Home alert scheduler: latches sensor events into a pending vector, serves them
// one at a time in priority order with a fixed hold time, and drives the heater or
// cooler when nothing is pending and the temperature is out of band.
module alert_scheduler
  import home_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned TEMP_LOW    = 50,
  parameter int unsigned TEMP_HIGH   = 70
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       SFA,
  input  logic       SFD,
  input  logic       SRD,
  input  logic       SW,
  input  logic [6:0] ST,
  output logic       alarmbuzz,
  output logic       fdoor,
  output logic       rdoor,
  output logic       winbuzz,
  output logic       heater,
  output logic       cooler,
  output logic [2:0] display,
  output logic       busy
);

  // Actuator vector layout: {alarmbuzz, fdoor, rdoor, winbuzz, heater, cooler}.
  // Pending bit i drives actuator bit i+2.
  localparam int unsigned ACT_HEATER = 1;
  localparam int unsigned ACT_COOLER = 0;

  state_t     state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic [1:0] grant_q, grant_d;
  logic [5:0] act_q, act_d;
  logic [2:0] display_q, display_d;
  logic       busy_q, busy_d;

  logic [3:0] sensors;
  logic [3:0] clr;
  logic [1:0] top_idx;
  logic       too_cold, too_hot;
  logic       tmr_load, tmr_dec, tmr_zero;

  assign sensors  = {SFA, SFD, SRD, SW};
  assign too_cold = ({25'd0, ST} < TEMP_LOW);
  assign too_hot  = ({25'd0, ST} > TEMP_HIGH);

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .Clk  (Clk),
    .Rst  (Rst),
    .load (tmr_load),
    .dec  (tmr_dec),
    .zero (tmr_zero)
  );

  // Priority encoder: fire > front door > rear door > window
  always_comb begin
    if (pend_q[PEND_FIRE]) begin
      top_idx = PEND_FIRE;
    end else if (pend_q[PEND_FDOOR]) begin
      top_idx = PEND_FDOOR;
    end else if (pend_q[PEND_RDOOR]) begin
      top_idx = PEND_RDOOR;
    end else begin
      top_idx = PEND_WIN;
    end
  end

  // FSM next state, timer control and pending-bit clear
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    clr      = 4'b0000;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q != 4'b0000) begin
          state_d  = ST_SERVE;
          grant_d  = top_idx;
          tmr_load = 1'b1;
        end else if (too_cold || too_hot) begin
          state_d = ST_CLIMATE;
        end
      end
      ST_SERVE: begin
        if (tmr_zero) begin
          state_d      = ST_GAP;
          clr[grant_q] = 1'b1;
        end else if ((grant_q != PEND_FIRE) && pend_q[PEND_FIRE]) begin
          // Fire preempts; the aborted request stays pending
          state_d = ST_GAP;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      ST_CLIMATE: begin
        if ((pend_q != 4'b0000) || !(too_cold || too_hot)) begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A sensor seen this edge wins over the clear of a completed service
    pend_d = (pend_q & ~clr) | sensors;
  end

  // Registered outputs are decoded from the state being entered
  always_comb begin
    act_d     = 6'b000000;
    display_d = DISP_NONE;
    busy_d    = (state_d == ST_SERVE) || (state_d == ST_GAP);
    if (state_d == ST_SERVE) begin
      act_d[3'(grant_d) + 3'd2] = 1'b1;
      display_d                 = disp_code(grant_d);
    end else if (state_d == ST_CLIMATE) begin
      if (too_cold) begin
        act_d[ACT_HEATER] = 1'b1;
        display_d         = DISP_HEATER;
      end else if (too_hot) begin
        act_d[ACT_COOLER] = 1'b1;
        display_d         = DISP_COOLER;
      end
    end
  end

  // State, pending vector and output registers; reset discards sensor samples
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= ST_IDLE;
      pend_q    <= 4'b0000;
      grant_q   <= PEND_WIN;
      act_q     <= 6'b000000;
      display_q <= DISP_NONE;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      grant_q   <= grant_d;
      act_q     <= act_d;
      display_q <= display_d;
      busy_q    <= busy_d;
    end
  end

  assign alarmbuzz = act_q[5];
  assign fdoor     = act_q[4];
  assign rdoor     = act_q[3];
  assign winbuzz   = act_q[2];
  assign heater    = act_q[ACT_HEATER];
  assign cooler    = act_q[ACT_COOLER];
  assign display   = display_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alert_scheduler.sv
// Self-checking bench for alert_scheduler: a table of directed vectors, hand-written
// multi-cycle sequences, and a randomized run checked against a behavioural model.
module tb_alert_scheduler;

  localparam int unsigned HOLD  = 8;
  localparam int unsigned TLOW  = 50;
  localparam int unsigned THIGH = 70;

  localparam logic [5:0] A_NONE = 6'b000000;
  localparam logic [5:0] A_FIRE = 6'b100000;
  localparam logic [5:0] A_FD   = 6'b010000;
  localparam logic [5:0] A_RD   = 6'b001000;
  localparam logic [5:0] A_WIN  = 6'b000100;
  localparam logic [5:0] A_HEAT = 6'b000010;
  localparam logic [5:0] A_COOL = 6'b000001;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       SFA = 1'b0, SFD = 1'b0, SRD = 1'b0, SW = 1'b0;
  logic [6:0] ST  = 7'd60;
  logic       alarmbuzz, fdoor, rdoor, winbuzz, heater, cooler, busy;
  logic [2:0] display;
  logic [5:0] acts;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: index being served (0 fire .. 3 window, -1 none),
  // cycles of hold left after the current one, one-cycle gap flag, climate mode.
  bit m_pend[4];
  int m_srv  = -1;
  int m_left = 0;
  bit m_gap  = 1'b0;
  int m_clim = 0;  // 0 off, 1 heating, 2 cooling

  alert_scheduler #(
    .HOLD_CYCLES(HOLD),
    .TEMP_LOW   (TLOW),
    .TEMP_HIGH  (THIGH)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .SFA       (SFA),
    .SFD       (SFD),
    .SRD       (SRD),
    .SW        (SW),
    .ST        (ST),
    .alarmbuzz (alarmbuzz),
    .fdoor     (fdoor),
    .rdoor     (rdoor),
    .winbuzz   (winbuzz),
    .heater    (heater),
    .cooler    (cooler),
    .display   (display),
    .busy      (busy)
  );

  assign acts = {alarmbuzz, fdoor, rdoor, winbuzz, heater, cooler};

  always #5 Clk = ~Clk;

  // Advance the model by one rising edge using the inputs present at that edge
  task automatic model_step();
    bit s[4];
    bit nxt[4];
    bit any;
    int first;
    s[0] = SFA; s[1] = SFD; s[2] = SRD; s[3] = SW;
    if (!Rst) begin
      for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
      m_srv = -1; m_left = 0; m_gap = 1'b0; m_clim = 0;
    end else begin
      any = 1'b0; first = -1;
      for (int i = 0; i < 4; i++) begin
        if (m_pend[i]) begin
          any = 1'b1;
          if (first < 0) first = i;
        end
      end
      nxt = m_pend;
      if (m_gap) begin
        m_gap = 1'b0;
      end else if (m_srv >= 0) begin
        if (m_left == 0) begin
          nxt[m_srv] = 1'b0; m_srv = -1; m_gap = 1'b1;
        end else if (m_srv != 0 && m_pend[0]) begin
          m_srv = -1; m_gap = 1'b1;
        end else begin
          m_left--;
        end
      end else if (m_clim != 0) begin
        if (any || (ST >= TLOW && ST <= THIGH)) begin
          m_clim = 0; m_gap = 1'b1;
        end else begin
          m_clim = (ST < TLOW) ? 1 : 2;
        end
      end else if (any) begin
        m_srv = first; m_left = HOLD - 1;
      end else if (ST < TLOW) begin
        m_clim = 1;
      end else if (ST > THIGH) begin
        m_clim = 2;
      end
      for (int i = 0; i < 4; i++) m_pend[i] = nxt[i] | s[i];
    end
  endtask

  task automatic model_exp(output logic [5:0] ea, output logic [2:0] ed, output logic eb);
    ea = A_NONE;
    ed = 3'd0;
    if (m_srv >= 0) begin
      ea[5 - m_srv] = 1'b1;
      ed = 3'(m_srv + 1);
    end else if (m_clim == 1) begin
      ea = A_HEAT; ed = 3'd5;
    end else if (m_clim == 2) begin
      ea = A_COOL; ed = 3'd6;
    end
    eb = (m_srv >= 0) || m_gap;
  endtask

  // One clock; sample #1 after the edge and check that at most one actuator is on
  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    n_checks++;
    if ($isunknown(acts) || $countones(acts) > 1) begin
      n_fail++;
      $display("FAIL onehot: actuators=%b, required at most one high", acts);
    end
  endtask

  task automatic check(input string name, input logic [5:0] ea, input logic [2:0] ed,
                       input logic eb);
    n_checks++;
    if (acts !== ea || display !== ed || busy !== eb) begin
      n_fail++;
      $display("FAIL %s @%0t: got act=%b disp=%b busy=%b, expected act=%b disp=%b busy=%b",
               name, $time, acts, display, busy, ea, ed, eb);
    end
  endtask

  task automatic hold(input string name, input logic [5:0] ea, input logic [2:0] ed,
                      input logic eb, input int n);
    repeat (n) begin
      tick();
      check(name, ea, ed, eb);
    end
  endtask

  typedef struct {
    logic       rst, sfa, sfd, srd, sw;
    logic [6:0] st;
    int         reps;
    logic [5:0] ea;
    logic [2:0] ed;
    logic       eb;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [5:0] ea;
    logic [2:0] ed;
    logic       eb;

    // Directed table: reset, single front-door event, climate band edges
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd60, 2, A_NONE, 3'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd60, 1, A_NONE, 3'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd60, 8, A_FD,   3'd2, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd60, 1, A_NONE, 3'd0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd60, 3, A_NONE, 3'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd40, 3, A_HEAT, 3'd5, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd60, 1, A_NONE, 3'd0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd60, 1, A_NONE, 3'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd90, 2, A_COOL, 3'd6, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd70, 1, A_NONE, 3'd0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd50, 2, A_NONE, 3'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd49, 1, A_HEAT, 3'd5, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd71, 1, A_COOL, 3'd6, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd60, 1, A_NONE, 3'd0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd60, 1, A_NONE, 3'd0, 1'b0});

    foreach (vecs[i]) begin
      Rst = vecs[i].rst; SFA = vecs[i].sfa; SFD = vecs[i].sfd;
      SRD = vecs[i].srd; SW = vecs[i].sw;   ST  = vecs[i].st;
      hold($sformatf("vec%0d", i), vecs[i].ea, vecs[i].ed, vecs[i].eb, vecs[i].reps);
    end
    SFA = 1'b0; SFD = 1'b0; SRD = 1'b0; SW = 1'b0; ST = 7'd60;

    // Simultaneous window, rear and front door: served in priority order
    SW = 1'b1; SRD = 1'b1; SFD = 1'b1;
    hold("simul_sample", A_NONE, 3'd0, 1'b0, 1);
    SW = 1'b0; SRD = 1'b0; SFD = 1'b0;
    hold("simul_fd",    A_FD,   3'd2, 1'b1, 8);
    hold("simul_gap1",  A_NONE, 3'd0, 1'b1, 1);
    hold("simul_idle1", A_NONE, 3'd0, 1'b0, 1);
    hold("simul_rd",    A_RD,   3'd3, 1'b1, 8);
    hold("simul_gap2",  A_NONE, 3'd0, 1'b1, 1);
    hold("simul_idle2", A_NONE, 3'd0, 1'b0, 1);
    hold("simul_win",   A_WIN,  3'd4, 1'b1, 8);
    hold("simul_gap3",  A_NONE, 3'd0, 1'b1, 1);
    hold("simul_idle3", A_NONE, 3'd0, 1'b0, 2);

    // Fire preempts rear door, rear door is then re-served in full
    SRD = 1'b1;
    hold("abort_sample", A_NONE, 3'd0, 1'b0, 1);
    SRD = 1'b0;
    hold("abort_rd3", A_RD, 3'd3, 1'b1, 3);
    SFA = 1'b1;
    hold("abort_rd4", A_RD, 3'd3, 1'b1, 1);
    SFA = 1'b0;
    hold("abort_gap1",  A_NONE, 3'd0, 1'b1, 1);
    hold("abort_idle1", A_NONE, 3'd0, 1'b0, 1);
    hold("abort_fire",  A_FIRE, 3'd1, 1'b1, 8);
    hold("abort_gap2",  A_NONE, 3'd0, 1'b1, 1);
    hold("abort_idle2", A_NONE, 3'd0, 1'b0, 1);
    hold("abort_rd_re", A_RD,   3'd3, 1'b1, 8);
    hold("abort_gap3",  A_NONE, 3'd0, 1'b1, 1);
    hold("abort_idle3", A_NONE, 3'd0, 1'b0, 2);

    // Window event interrupts heating; heating resumes afterwards
    ST = 7'd40;
    hold("clim_heat", A_HEAT, 3'd5, 1'b0, 3);
    SW = 1'b1;
    hold("clim_heat_sw", A_HEAT, 3'd5, 1'b0, 1);
    SW = 1'b0;
    hold("clim_gap1",  A_NONE, 3'd0, 1'b1, 1);
    hold("clim_idle1", A_NONE, 3'd0, 1'b0, 1);
    hold("clim_win",   A_WIN,  3'd4, 1'b1, 8);
    hold("clim_gap2",  A_NONE, 3'd0, 1'b1, 1);
    hold("clim_idle2", A_NONE, 3'd0, 1'b0, 1);
    hold("clim_resume", A_HEAT, 3'd5, 1'b0, 2);
    ST = 7'd60;
    hold("clim_gap3",  A_NONE, 3'd0, 1'b1, 1);
    hold("clim_idle3", A_NONE, 3'd0, 1'b0, 1);

    // Reset mid-service with the sensor high on the reset edge
    SFD = 1'b1;
    hold("rst_sample", A_NONE, 3'd0, 1'b0, 1);
    SFD = 1'b0;
    hold("rst_fd3", A_FD, 3'd2, 1'b1, 3);
    Rst = 1'b0; SFD = 1'b1;
    hold("rst_edge", A_NONE, 3'd0, 1'b0, 1);
    Rst = 1'b1; SFD = 1'b0;
    hold("rst_discard", A_NONE, 3'd0, 1'b0, 3);
    SFD = 1'b1;
    hold("rst_resample", A_NONE, 3'd0, 1'b0, 1);
    SFD = 1'b0;
    hold("rst_fd_full", A_FD,   3'd2, 1'b1, 8);
    hold("rst_gap",     A_NONE, 3'd0, 1'b1, 1);
    hold("rst_idle",    A_NONE, 3'd0, 1'b0, 1);

    // Randomized run against the behavioural model; sensors behave as levels
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      SFA = SFA ? ($urandom_range(2) != 0) : ($urandom_range(39) == 0);
      SFD = SFD ? ($urandom_range(2) != 0) : ($urandom_range(14) == 0);
      SRD = SRD ? ($urandom_range(2) != 0) : ($urandom_range(14) == 0);
      SW  = SW  ? ($urandom_range(2) != 0) : ($urandom_range(14) == 0);
      if ($urandom_range(19) == 0) ST = 7'($urandom_range(100, 30));
      Rst = ($urandom_range(299) != 0);
      tick();
      model_exp(ea, ed, eb);
      check($sformatf("rand%0d", c), ea, ed, eb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alert_scheduler.md
ALERT_SCHEDULER -- requirements
Module: alert_scheduler

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 8, meaning cycles one event output stays asserted (legal range 1..255).
REQ-002 SHALL have parameter TEMP_LOW, default 50, meaning heater request when ST < TEMP_LOW.
REQ-003 SHALL have parameter TEMP_HIGH, default 70, meaning cooler request when ST > TEMP_HIGH (TEMP_LOW <= TEMP_HIGH).
REQ-004 SHALL have ports: Clk in 1 single clock, rising edge; Rst in 1 reset.
REQ-005 Rst SHALL be synchronous and active-low: the block resets on a rising Clk edge where Rst=0.
REQ-006 SHALL have inputs SFA, SFD, SRD, SW, each 1 bit: fire, front-door, rear-door and window sensors, active-high.
REQ-007 SHALL have input ST, 7 bits, unsigned temperature.
REQ-008 SHALL have registered outputs alarmbuzz, fdoor, rdoor, winbuzz, heater, cooler, each 1 bit.
REQ-009 SHALL have registered output display, 3 bits, and registered output busy, 1 bit: high in SERVE or GAP.

Function
REQ-010 Pending vector pend[3:0] (fire, fdoor, rdoor, window): bit set at any edge where its sensor=1; set wins over a same-cycle clear.
REQ-011 Priority SHALL be fire > front door > rear door > window > climate.
REQ-012 States SHALL be IDLE, SERVE, GAP, CLIMATE.
REQ-013 IDLE, pend!=0: next edge -> SERVE granting highest pending bit; its output and display asserted from that edge; timer loaded HOLD_CYCLES-1.
REQ-014 IDLE, pend==0, ST<TEMP_LOW or ST>TEMP_HIGH: next edge -> CLIMATE with heater or cooler respectively; else stay IDLE, all outputs 0.
REQ-015 SERVE: timer decrements each cycle; at timer==0 next edge -> GAP, granted pend bit cleared (subject to REQ-010).
REQ-016 SERVE of non-fire with pend[fire]=1: next edge -> GAP immediately; aborted request's pend bit retained.
REQ-017 GAP: exactly one cycle, all actuator outputs 0, display 000; then -> IDLE.
REQ-018 CLIMATE: exit to GAP on the edge after pend!=0 or ST returns within [TEMP_LOW, TEMP_HIGH]; heater/cooler re-evaluated each cycle otherwise.
REQ-019 At most one of the six actuator outputs SHALL be high in any cycle; heater and cooler never both.
REQ-020 display codes: 000 none, 001 fire, 010 fdoor, 011 rdoor, 100 window, 101 heater, 110 cooler; 111 unused.
REQ-021 Latency: sensor rising at edge k -> pend at k -> output asserted at edge k+1 when IDLE (2 edges from sample).
REQ-022 Sensor held high continuously SHALL be re-served after each GAP (level semantics, no starvation of higher priority).
REQ-023 Simultaneous sensors SHALL be served one at a time in priority order, each separated by GAP.

Reset
REQ-024 On reset: state IDLE, pend=0, timer=0, all actuator outputs 0, display 000, busy 0.
REQ-025 Reset mid-SERVE or mid-CLIMATE SHALL abandon the service; sensor samples on the reset edge SHALL be discarded.

Structure
REQ-026 Shared package home_pkg SHALL hold the state enum, display code constants and pend bit indices.
REQ-027 Hold counter SHALL be a sub-module hold_timer (load, decrement, zero flag, width from HOLD_CYCLES).
REQ-028 Priority encoder and FSM reside in alert_scheduler; all outputs from flops.

Verification
REQ-029 Reset, SFD pulse 1 cycle: fdoor=1, display=010 for exactly 8 cycles, GAP, then IDLE; pend cleared.
REQ-030 SW, SRD, SFD all rise same edge: service order fdoor, rdoor, winbuzz, each 8 cycles, 1-cycle GAP between.
REQ-031 SRD served 3 cycles, SFA pulses: rdoor drops next edge, GAP, alarmbuzz 8 cycles, then rdoor re-served full 8 cycles.
REQ-032 ST=40, no sensors: heater=1, display=101; ST->60: GAP then IDLE; ST=90: cooler=1, display=110.
REQ-033 CLIMATE heater, SW pulse: heater drops next edge, GAP, winbuzz 8 cycles, heater resumes if ST still 40.
REQ-034 Rst=0 for one edge mid-SERVE with SFD high during it: all outputs 0 next cycle, fdoor re-granted only after SFD sampled post-reset; one-hot check (REQ-019) asserted throughout.
